// File: rtl/irq_timer.sv
// irq_timer: memory-mapped countdown timer that raises an interrupt request
// toward CP0. Three word registers: CTRL (EN, MODE, IM), PRESET (reload
// value) and COUNT (read-only live counter). The irq output is the pending
// flag gated by CTRL.IM. Software clears a pending request by rewriting
// CTRL or PRESET.
module irq_timer #(
  parameter int CNT_W = 32  // PRESET/COUNT width, 2..32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  addr,
  input  logic        we,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CNT  = 2'd2,
    INT  = 2'd3
  } state_t;

  localparam logic [1:0]       A_CTRL   = 2'd0;
  localparam logic [1:0]       A_PRESET = 2'd1;
  localparam logic [1:0]       A_COUNT  = 2'd2;
  localparam logic [1:0]       MODE_PER = 2'd1;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state, state_nxt;
  logic             en, en_nxt;
  logic [1:0]       mode, mode_nxt;
  logic             im, im_nxt;
  logic [CNT_W-1:0] preset, preset_nxt;
  logic [CNT_W-1:0] count, count_nxt;
  logic             irq_flag, irq_flag_nxt;

  logic wr_ctrl;
  logic wr_preset;

  assign wr_ctrl   = we && (addr == A_CTRL);
  assign wr_preset = we && (addr == A_PRESET);

  // Next-state logic: CPU writes are applied first, then the FSM may
  // override, so an FSM flag set beats a write clear on the same edge.
  always_comb begin
    // NOTE: every signal assigned here gets a default first; a path that
    // leaves one unassigned would otherwise infer a latch.
    state_nxt    = state;
    en_nxt       = en;
    mode_nxt     = mode;
    im_nxt       = im;
    preset_nxt   = preset;
    count_nxt    = count;
    irq_flag_nxt = irq_flag;

    if (wr_ctrl) begin
      en_nxt       = wdata[0];
      mode_nxt     = wdata[2:1];
      im_nxt       = wdata[3];
      irq_flag_nxt = 1'b0;
    end
    if (wr_preset) begin
      preset_nxt   = wdata[CNT_W-1:0];
      irq_flag_nxt = 1'b0;
    end

    case (state)
      IDLE: begin
        if (en) state_nxt = LOAD;
      end
      LOAD: begin
        count_nxt = preset;
        state_nxt = CNT;
      end
      CNT: begin
        if (!en) begin
          state_nxt = IDLE;
        end else if (count > CNT_ONE) begin
          count_nxt = count - CNT_ONE;
        end else begin
          // COUNT of 0 or 1 terminates the count without wrapping.
          count_nxt    = '0;
          irq_flag_nxt = 1'b1;
          state_nxt    = INT;
        end
      end
      INT: begin
        if (mode == MODE_PER) begin
          irq_flag_nxt = 1'b0;
          state_nxt    = LOAD;
        end else begin
          // One-shot: drop EN unless the CPU is writing CTRL this edge.
          if (!wr_ctrl) en_nxt = 1'b0;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State and register update with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    if (reset) begin
      state    <= IDLE;
      en       <= 1'b0;
      mode     <= 2'd0;
      im       <= 1'b0;
      preset   <= '0;
      count    <= '0;
      irq_flag <= 1'b0;
    end else begin
      state    <= state_nxt;
      en       <= en_nxt;
      mode     <= mode_nxt;
      im       <= im_nxt;
      preset   <= preset_nxt;
      count    <= count_nxt;
      irq_flag <= irq_flag_nxt;
    end
  end

  // Combinational read mux; unused and reserved bits read as zero.
  always_comb begin
    rdata = '0;
    case (addr)
      A_CTRL:   rdata = {28'd0, im, mode, en};
      A_PRESET: rdata[CNT_W-1:0] = preset;
      A_COUNT:  rdata[CNT_W-1:0] = count;
      default:  rdata = '0;
    endcase
  end

  assign irq = irq_flag & im;

endmodule
